// File: rtl/tdm_demux.sv
// Serial-to-parallel TDM demultiplexer: reassembles sync-aligned frames of
// CH_NUM channels x CH_WIDTH bits and presents them on a registered bus.
module tdm_demux #(
  parameter int CH_NUM   = 2,
  parameter int CH_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         din,
  input  logic                         din_vld,
  input  logic                         sync,
  output logic [CH_NUM*CH_WIDTH-1:0]   dout,
  output logic                         dout_vld,
  output logic                         frame_err,
  output logic                         busy
);

  localparam int FRAME_BITS = CH_NUM * CH_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   sreg_q, sreg_d;
  logic [FRAME_BITS-1:0]   dout_q, dout_d;
  logic                    dout_vld_q, dout_vld_d;
  logic                    frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      bit_cnt_q   <= '0;
      sreg_q      <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sreg_q      <= sreg_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sreg_d      = sreg_q;
    dout_d      = dout_q;
    dout_vld_d  = 1'b0;
    frame_err_d = 1'b0;

    if (din_vld) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            sreg_d    = {{(FRAME_BITS-1){1'b0}}, din};
            bit_cnt_d = CNT_W'(1);
            state_d   = RECV;
          end
        end
        RECV: begin
          // An early sync abandons the partial frame and restarts on this bit
          if (sync) begin
            frame_err_d = 1'b1;
            sreg_d      = {{(FRAME_BITS-1){1'b0}}, din};
            bit_cnt_d   = CNT_W'(1);
          end else if (bit_cnt_q == LAST_BIT) begin
            dout_d     = {sreg_q[FRAME_BITS-2:0], din};
            dout_vld_d = 1'b1;
            bit_cnt_d  = '0;
            state_d    = HUNT;
          end else begin
            sreg_d    = {sreg_q[FRAME_BITS-2:0], din};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux with the default 2x4 geometry.
module tb_tdm_demux;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_vld;
  logic       sync;
  logic [7:0] dout;
  logic       dout_vld;
  logic       frame_err;
  logic       busy;

  int nChecks = 0;
  int nErrs   = 0;
  int cyc     = 0;

  tdm_demux #(.CH_NUM(2), .CH_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .sync      (sync),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive on the falling edge, then sample just after the next rising edge
  task automatic applyStimulus(input logic v, input logic s, input logic d);
    @(negedge clk);
    din_vld = v;
    sync    = s;
    din     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrs++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one frame with sync on its first bit and checks every cycle
  task automatic sendFrame(input logic [7:0] f, input logic earlyErr,
                           input logic [7:0] prevDout, output int vldCyc);
    vldCyc = -1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, (i == 0), f[7-i]);
      checkOutput("frame_err", {31'd0, frame_err}, {31'd0, (i == 0) && earlyErr});
      if (i < 7) begin
        checkOutput("vld_mid", {31'd0, dout_vld}, 32'd0);
        checkOutput("busy_mid", {31'd0, busy}, 32'd1);
        checkOutput("dout_hold", {24'd0, dout}, {24'd0, prevDout});
      end else begin
        checkOutput("vld_last", {31'd0, dout_vld}, 32'd1);
        checkOutput("busy_last", {31'd0, busy}, 32'd0);
        checkOutput("dout_frame", {24'd0, dout}, {24'd0, f});
        vldCyc = cyc;
      end
    end
  endtask

  initial begin
    int vldA;
    int vldB;
    int vldCount;
    logic [7:0] stallFrame;
    logic [7:0] partial;

    rst_n   = 1'b0;
    din     = 1'b0;
    din_vld = 1'b0;
    sync    = 1'b0;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom));
      checkOutput("rst_dout", {24'd0, dout}, 32'h00);
      checkOutput("rst_vld", {31'd0, dout_vld}, 32'd0);
      checkOutput("rst_err", {31'd0, frame_err}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    din_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'($urandom), 1'($urandom));
      checkOutput("post_rst_dout", {24'd0, dout}, 32'h00);
      checkOutput("post_rst_vld", {31'd0, dout_vld}, 32'd0);
      checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
    end

    $display("[TB] basic frame 8'hA3");
    sendFrame(8'hA3, 1'b0, 8'h00, vldA);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("basic_vld_drop", {31'd0, dout_vld}, 32'd0);
    checkOutput("basic_hold", {24'd0, dout}, 32'hA3);

    $display("[TB] stalled frame 8'hA3");
    stallFrame = 8'hA3;
    vldCount   = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, (i == 0), stallFrame[7-i]);
      if (dout_vld) vldCount++;
      checkOutput("stall_err_a", {31'd0, frame_err}, 32'd0);
      checkOutput("stall_busy_a", {31'd0, busy}, {31'd0, (i < 7)});
      applyStimulus(1'b0, 1'b1, 1'($urandom));
      if (dout_vld) vldCount++;
      checkOutput("stall_err_b", {31'd0, frame_err}, 32'd0);
      checkOutput("stall_busy_b", {31'd0, busy}, {31'd0, (i < 7)});
    end
    checkOutput("stall_vld_count", vldCount, 32'd1);
    checkOutput("stall_dout", {24'd0, dout}, 32'hA3);

    $display("[TB] pre-sync garbage then 8'h5C");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("garbage_busy", {31'd0, busy}, 32'd0);
      checkOutput("garbage_vld", {31'd0, dout_vld}, 32'd0);
    end
    sendFrame(8'h5C, 1'b0, 8'hA3, vldA);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("garbage_vld_drop", {31'd0, dout_vld}, 32'd0);

    $display("[TB] early sync then 8'hF0");
    partial = 8'b11001000;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, (i == 0), partial[7-i]);
      checkOutput("partial_err", {31'd0, frame_err}, 32'd0);
      checkOutput("partial_busy", {31'd0, busy}, 32'd1);
    end
    sendFrame(8'hF0, 1'b1, 8'h5C, vldA);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("early_err_drop", {31'd0, frame_err}, 32'd0);

    $display("[TB] back-to-back 8'h12, 8'h34");
    sendFrame(8'h12, 1'b0, 8'hF0, vldA);
    sendFrame(8'h34, 1'b0, 8'h12, vldB);
    checkOutput("b2b_spacing", vldB - vldA, 32'd8);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, (i == 0), 1'b1);
    end
    checkOutput("third_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_dout", {24'd0, dout}, 32'h00);
    checkOutput("midrst_vld", {31'd0, dout_vld}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("after_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("after_rst_vld", {31'd0, dout_vld}, 32'd0);
      checkOutput("after_rst_dout", {24'd0, dout}, 32'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrs);
    $finish;
  end

endmodule
